// File: rtl/bram_arb_pkg.sv
// Shared constants and round-robin search helper for bram_port_arbiter.
// Optional feature macro: BRAM_ARB_RAW_BYPASS_EN (see bram_port_arbiter.sv).
package bram_arb_pkg;

    localparam int N_REQ_DEF      = 4;
    localparam int WIDTH_BITS_DEF = 32;
    localparam int DEPTH_DEF      = 1024;
    localparam int MAX_REQ        = 32;

    // Index of first set bit at or after ptr (cyclic over n), -1 if none.
    function automatic int rr_search(
        input logic [MAX_REQ-1:0] valid,
        input int                 ptr,
        input int                 n
    );
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = n;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < n && valid[i]) begin
                d = (i - ptr + n) % n;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side read/write handshake bundle for bram_port_arbiter.
// Optional feature macro: BRAM_ARB_RAW_BYPASS_EN (no effect on this file).
interface bram_port_arbiter_if #(
    parameter int N  = 4,
    parameter int AW = 10,
    parameter int DW = 32
);

    logic [N-1:0]         rd_req_valid;
    logic [N-1:0][AW-1:0] rd_req_addr;
    logic [N-1:0]         rd_req_ready;
    logic [N-1:0]         rd_resp_valid;
    logic [DW-1:0]        rd_resp_data;
    logic [N-1:0]         wr_req_valid;
    logic [N-1:0][AW-1:0] wr_req_addr;
    logic [N-1:0][DW-1:0] wr_req_data;
    logic [N-1:0]         wr_req_ready;

    modport master (
        output rd_req_valid, rd_req_addr,
        output wr_req_valid, wr_req_addr, wr_req_data,
        input  rd_req_ready, rd_resp_valid, rd_resp_data,
        input  wr_req_ready
    );

    modport slave (
        input  rd_req_valid, rd_req_addr,
        input  wr_req_valid, wr_req_addr, wr_req_data,
        output rd_req_ready, rd_resp_valid, rd_resp_data,
        output wr_req_ready
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from valid, pointer advances past grantee.
// Optional feature macro: BRAM_ARB_RAW_BYPASS_EN (no effect on this file).
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [N-1:0] valid,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      ptr_nxt;
    logic [MAX_REQ-1:0] vext;
    int                 sel;

    always_comb begin
        vext         = '0;
        vext[N-1:0]  = valid;
        sel          = rr_search(vext, int'(ptr), N);
        grant        = '0;
        ptr_nxt      = ptr;
        for (int i = 0; i < N; i++) begin
            grant[i] = (sel == i);
        end
        if (sel >= 0) begin
            ptr_nxt = PW'((sel + 1) % N);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin front end sharing one simple dual-port BRAM among N_REQ requesters.
// Define BRAM_ARB_RAW_BYPASS_EN to forward same-cycle write data to a colliding read.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter  int N_REQ      = N_REQ_DEF,
    parameter  int DEPTH      = DEPTH_DEF,
    parameter  int WIDTH_BITS = WIDTH_BITS_DEF,
    localparam int NBITS_ADDR = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    bram_port_arbiter_if.slave    bus,
    output logic                  bram_read_en,
    output logic [NBITS_ADDR-1:0] bram_addr_read,
    output logic                  bram_write_en,
    output logic [NBITS_ADDR-1:0] bram_addr_write,
    output logic [WIDTH_BITS-1:0] bram_data_in,
    input  logic [WIDTH_BITS-1:0] bram_data_out
);

    logic [N_REQ-1:0]      rd_gnt;
    logic [N_REQ-1:0]      wr_gnt;
    logic [N_REQ-1:0]      rd_vld;
    logic [N_REQ-1:0]      wr_vld;
    logic [N_REQ-1:0]      tag_q;
    logic [WIDTH_BITS-1:0] rsp_word;

    // Masking valid keeps grants, enables and pointer motion off in reset.
    assign rd_vld = bus.rd_req_valid & {N_REQ{resetn}};
    assign wr_vld = bus.wr_req_valid & {N_REQ{resetn}};

    rr_arbiter #(.N(N_REQ)) u_rd_arb (
        .clk     (clk),
        .resetn  (resetn),
        .valid   (rd_vld),
        .advance (|rd_gnt),
        .grant   (rd_gnt)
    );

    rr_arbiter #(.N(N_REQ)) u_wr_arb (
        .clk     (clk),
        .resetn  (resetn),
        .valid   (wr_vld),
        .advance (|wr_gnt),
        .grant   (wr_gnt)
    );

    assign bus.rd_req_ready = rd_gnt;
    assign bus.wr_req_ready = wr_gnt;
    assign bram_read_en     = |rd_gnt;
    assign bram_write_en    = |wr_gnt;

    always_comb begin
        bram_addr_read  = '0;
        bram_addr_write = '0;
        bram_data_in    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (rd_gnt[i]) bram_addr_read  |= bus.rd_req_addr[i];
            if (wr_gnt[i]) bram_addr_write |= bus.wr_req_addr[i];
            if (wr_gnt[i]) bram_data_in    |= bus.wr_req_data[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tag_q <= '0;
        end else begin
            tag_q <= rd_gnt;
        end
    end

`ifdef BRAM_ARB_RAW_BYPASS_EN
    logic                  byp_q;
    logic [WIDTH_BITS-1:0] byp_data_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_q      <= bram_read_en && bram_write_en &&
                          (bram_addr_read == bram_addr_write);
            byp_data_q <= bram_data_in;
        end
    end

    assign rsp_word = byp_q ? byp_data_q : bram_data_out;
`else
    assign rsp_word = bram_data_out;
`endif

    assign bus.rd_resp_valid = tag_q;
    assign bus.rd_resp_data  = (|tag_q) ? rsp_word : '0;

endmodule
